// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between two requesters.
// Optional watchdog abort of a stuck engine: define I2C_ARB_WATCHDOG_EN.

// state | meaning
// IDLE  | bus free, evaluate req and latch winner's command
// START | one-cycle m_start pulse to the engine
// WAIT  | engine busy, wait for m_done (or watchdog expiry)
// RESP  | one-cycle done pulse to owner, gnt drops at end
module i2c_bus_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req,
  input  logic [ADDR_W+DATA_W:0]   cmd0,
  input  logic [ADDR_W+DATA_W:0]   cmd1,
  output logic [1:0]               gnt,
  output logic [1:0]               done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     nack,
  output logic                     timeout,
  output logic                     sel,
  output logic                     m_start,
  output logic [ADDR_W+DATA_W:0]   m_cmd,
  input  logic                     m_done,
  input  logic                     m_nack,
  input  logic [DATA_W-1:0]        m_rdata,
  output logic                     m_abort
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t state, state_nx;
  logic   last;
  logic   winner;
  logic   grant;
  logic   wd_hit;

  // On a tie the requester that did not own the last transaction wins.
  assign winner  = (req == 2'b11) ? ~last : req[1];
  assign grant   = (state == IDLE) && (req != 2'b00);
  assign m_start = (state == START);
  assign done    = (state == RESP) ? (sel ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req != 2'b00) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (m_done || wd_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 2'b00;
      sel   <= 1'b0;
      m_cmd <= '0;
      rdata <= '0;
      nack  <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      if (grant) begin
        sel   <= winner;
        gnt   <= winner ? 2'b10 : 2'b01;
        m_cmd <= winner ? cmd1 : cmd0;
      end else if (state == RESP) begin
        gnt <= 2'b00;
      end
      if (state == WAIT && m_done) begin
        rdata <= m_rdata;
        nack  <= m_nack;
        last  <= sel;
      end else if (wd_hit) begin
        rdata <= '0;
        nack  <= 1'b1;
        last  <= sel;
      end
    end
  end

`ifdef I2C_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // Down-counter loaded on the way into WAIT; terminal count means TIMEOUT WAIT cycles elapsed.
  assign wd_hit  = (state == WAIT) && !m_done && (wd_cnt == '0);
  assign m_abort = wd_hit;
  assign timeout = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == START)
        wd_cnt <= WD_W'(TIMEOUT);
      else if (state == WAIT && wd_cnt != '0)
        wd_cnt <= wd_cnt - 1'b1;
      if (state == WAIT && (m_done || wd_hit))
        timeout_q <= wd_hit;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign m_abort = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed plan steps plus randomized
// transactions checked against a round-robin ownership model.
module tb_i2c_bus_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int CW     = 1 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req;
  logic [CW-1:0]     cmd0, cmd1;
  logic [1:0]        gnt, done;
  logic [DATA_W-1:0] rdata;
  logic              nack, timeout, sel, m_start, m_abort;
  logic [CW-1:0]     m_cmd;
  logic              m_done, m_nack;
  logic [DATA_W-1:0] m_rdata;

  int npass  = 0;
  int ntotal = 0;
  int model_last = 1;   // owner of the previous transaction, per the model
  int obs_sel;

  i2c_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .cmd0(cmd0), .cmd1(cmd1),
    .gnt(gnt), .done(done), .rdata(rdata), .nack(nack), .timeout(timeout),
    .sel(sel), .m_start(m_start), .m_cmd(m_cmd), .m_done(m_done),
    .m_nack(m_nack), .m_rdata(m_rdata), .m_abort(m_abort)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return 1 - model_last;
    return r[1] ? 1 : 0;
  endfunction

  // One full transaction starting with the DUT in IDLE; returns with the DUT back in IDLE.
  task automatic txn(input logic [1:0] r, input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                     input int lat, input logic [7:0] rd, input logic nk, input bit disturb);
    int            w;
    logic [CW-1:0] expc;
    w    = pick(r);
    expc = (w == 1) ? c1 : c0;
    req  = r;
    cmd0 = c0;
    cmd1 = c1;
    tick();
    chk("gnt_start", gnt, 32'(1 << w));
    chk("sel", sel, w);
    chk("m_cmd", m_cmd, expc);
    chk("m_start_hi", m_start, 1);
    obs_sel = sel;
    tick();
    chk("m_start_lo", m_start, 0);
    if (disturb) begin
      cmd0 = ~c0;
      cmd1 = ~c1;
      req  = 2'b00;
    end
    for (int i = 1; i < lat; i++) tick();
    chk("no_early_done", done, 0);
    m_done  = 1'b1;
    m_rdata = rd;
    m_nack  = nk;
    tick();
    m_done  = 1'b0;
    m_rdata = 8'($urandom);
    m_nack  = 1'b0;
    chk("done", done, 32'(1 << w));
    chk("rdata", rdata, rd);
    chk("nack", nack, nk);
    chk("timeout_lo", timeout, 0);
    chk("m_cmd_hold", m_cmd, expc);
    chk("gnt_resp", gnt, 32'(1 << w));
    model_last = w;
    req = 2'b00;
    tick();
    chk("done_clr", done, 0);
    chk("gnt_clr", gnt, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_misc"}, {rdata, nack, timeout, sel, m_start, m_abort}, 0);
    chk({tag, "_m_cmd"}, m_cmd, 0);
  endtask

  initial begin
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    reset = 1'b1; req = 2'b00; cmd0 = '0; cmd1 = '0;
    m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    model_last = 1;
    tick();

    // Single requester 0 write, engine takes 10 cycles
    txn(2'b01, {1'b0, 7'h48, 8'hA5}, '0, 10, 8'h00, 1'b0, 1'b0);

    // Requester 1 read with NACK
    txn(2'b10, '0, {1'b1, 7'h50, 8'h00}, 3, 8'h3C, 1'b1, 1'b0);

    // Both requesting: alternate starting with 0 (last owner was 1)
    for (int k = 0; k < 4; k++) begin
      txn(2'b11, CW'($urandom), CW'($urandom), 1 + k, 8'($urandom), 1'($urandom), 1'b0);
      chk("rr_order", obs_sel, exp_order[k]);
    end

    // Drop req and change cmd during WAIT: transaction completes unchanged
    txn(2'b01, {1'b0, 7'h22, 8'h5A}, '0, 4, 8'h00, 1'b0, 1'b1);

    // Spurious m_done in IDLE
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("spurious_done", done, 0);
    tick();
    chk("spurious_done2", done, 0);
    chk("spurious_gnt", gnt, 0);

    // Reset during WAIT, then a tie goes to requester 0
    req = 2'b11; cmd0 = 16'h1234; cmd1 = 16'h5678;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    model_last = 1;
    req = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    txn(2'b11, 16'h0ABC, 16'h0DEF, 2, 8'h77, 1'b0, 1'b0);
    chk("tie_after_reset", obs_sel, 0);

    // Randomized traffic against the ownership model
    for (int k = 0; k < 30; k++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      txn(r, CW'($urandom), CW'($urandom), $urandom_range(1, 8),
          8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) tick();
    end

`ifdef I2C_ARB_WATCHDOG_EN
    begin
      int w;
      w = pick(2'b10);
      req = 2'b10; cmd1 = 16'hC0DE;
      tick();
      chk("wd_gnt", gnt, 32'(1 << w));
      tick();
      for (int i = 0; i < 16; i++) begin
        chk("wd_no_abort", m_abort, 0);
        tick();
      end
      chk("wd_abort", m_abort, 1);
      tick();
      chk("wd_abort_pulse", m_abort, 0);
      chk("wd_done", done, 32'(1 << w));
      chk("wd_nack", nack, 1);
      chk("wd_timeout", timeout, 1);
      chk("wd_rdata", rdata, 0);
      model_last = w;
      req = 2'b00;
      tick();
      chk("wd_idle", gnt, 0);
      txn(2'b11, 16'h1111, 16'h2222, 2, 8'h99, 1'b0, 1'b0);
    end
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
Shares the single I2C master engine between two requesters (e.g. sensor poller and config loader), one transaction at a time.
Arbitrates round-robin, drives the select line of the 2:1 command/response mux, and latches the winner's command.
Sequences the engine start/done handshake and returns read data and ACK status to the winning requester.

Parameters:
ADDR_W, 7, I2C slave address width
DATA_W, 8, data byte width
TIMEOUT, 4095, watchdog limit in clk cycles (used only with I2C_ARB_WATCHDOG_EN)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req  in  2  req[i] = requester i wants the bus; held high until done[i]
cmd0  in  1+ADDR_W+DATA_W  requester 0 command {rw, addr, wdata}; rw=1 is read
cmd1  in  1+ADDR_W+DATA_W  requester 1 command, same packing
gnt  out  2  one-hot owner flag, high from grant through the RESP cycle
done  out  2  one-cycle completion pulse to the owner
rdata  out  DATA_W  read byte, valid while done != 0
nack  out  1  slave NACK or timeout, valid while done != 0
timeout  out  1  watchdog expiry, valid while done != 0 (always 0 without the macro)
sel  out  1  mux select: 0 = requester 0, 1 = requester 1
m_start  out  1  one-cycle start pulse to the engine
m_cmd  out  1+ADDR_W+DATA_W  registered command to the engine, stable START through WAIT
m_done  in  1  engine completion pulse
m_nack  in  1  engine NACK, sampled with m_done
m_rdata  in  DATA_W  engine read byte, sampled with m_done
m_abort  out  1  one-cycle abort pulse to the engine (always 0 without the macro)

Behaviour:
- Reset: state=IDLE; gnt, done, rdata, nack, timeout, sel, m_start, m_cmd, m_abort = 0; last=1, so requester 0 wins the first tie.
- FSM: IDLE -> START -> WAIT -> RESP -> IDLE.
- IDLE: if req != 0, pick the winner. For req=2'b11 the winner is ~last; otherwise it is the single requester. Register sel=winner, gnt[winner]=1, m_cmd=cmd[winner], then go to START.
- START: m_start=1 for exactly one cycle, then go to WAIT.
- WAIT: hold until m_done=1. On that edge, capture m_rdata and m_nack, set last=sel, and go to RESP.
- RESP: done[sel]=1 for one cycle with rdata and nack valid. At the end of the cycle gnt=0 and the FSM returns to IDLE.
- Latency: req rising in IDLE at edge N gives gnt at N+1, m_start high in cycle N+1..N+2, and done one cycle after the m_done edge.
- Minimum turnaround: 4 cycles per transaction, plus engine time.
- Back-to-back with both requesting: grants alternate 0,1,0,1. A single persistent requester is re-granted every pass.
- Requests are only evaluated in IDLE. A req change during START, WAIT or RESP does not affect the transaction in flight. Dropping req mid-transaction does not cancel it; done still pulses.
- m_done outside WAIT is ignored. m_done arriving in the same cycle as m_start is not expected; the engine's minimum response is 1 cycle after m_start.
- cmd inputs are sampled only at the grant edge; later changes do not alter m_cmd.
- Asynchronous reset mid-transaction: immediately returns to IDLE with all outputs at reset values. No done pulse; the engine is reset by the same signal.
- rdata, nack and timeout hold their last values after RESP; they are only meaningful with done.

Optional Feature:
- I2C_ARB_WATCHDOG_EN defined: a counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no m_done: m_abort=1 for one cycle, go to RESP with nack=1, timeout=1, rdata=0, and update last.
  - If m_done arrives in the same cycle the counter hits TIMEOUT, m_done wins.
- Undefined: no counter; WAIT lasts until m_done indefinitely; m_abort and timeout are tied to 0.

Test Plan:
- Reset then req=2'b01, cmd0 write {0,7'h48,8'hA5} -> gnt=01, sel=0, m_cmd={0,48,A5}, one-cycle m_start; m_done after 10 cycles -> done=01 one cycle later, nack=0.
- req=2'b11 held for 4 transactions -> grant order 0,1,0,1; sel matches each grant; no overlapping gnt.
- Requester 1 read at 7'h50; engine returns m_rdata=8'h3C, m_nack=1 -> done=10 with rdata=3C, nack=1.
- During WAIT, change cmd0 and drop req[0] -> m_cmd unchanged and done[0] still pulses; a spurious m_done in IDLE produces no done.
- Assert reset in WAIT -> all outputs 0 immediately; next tie goes to requester 0.
- With I2C_ARB_WATCHDOG_EN and TIMEOUT=16, no m_done -> m_abort after 16 WAIT cycles, then done with nack=1, timeout=1.
